// File: rtl/mux_share_arbiter_pkg.sv
// Shared types and helpers for the mux-sharing round-robin arbiter.
// The timeout feature is selected with MUX_SHARE_ARB_TIMEOUT_EN in the top.
package mux_share_pkg;

  localparam int MAXN = 16;
  localparam int IDXW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

  function automatic logic [MAXN-1:0] onehot(
    input logic [IDXW-1:0] idx
  );
    logic [MAXN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux_share_arbiter_if.sv
// Requester-side bundle of the mux-sharing arbiter.
// master drives req/done, slave (the arbiter) drives ownership.
interface mux_share_arbiter_if #(
  parameter int N = 4
) ();

  localparam int SELW = $clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N-1:0]    grant;
  logic [SELW-1:0] sel;
  logic            busy;
  logic            timeout;

  modport master (
    output req, done,
    input  grant, sel, busy, timeout
  );

  modport slave (
    input  req, done,
    output grant, sel, busy, timeout
  );

endinterface

// File: rtl/mux_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr.
// Rotates the request vector so the search always starts at bit 0.
module rr_pick #(
  parameter int N    = 4,
  parameter int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] win,
  output logic            valid
);

  logic [N-1:0]    rot;
  logic [SELW-1:0] off;
  logic [SELW:0]   sum;

  assign rot   = N'({req, req} >> ptr);
  assign valid = |req;

  always_comb begin
    off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) off = SELW'(k);
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};

  always_comb begin
    if (sum >= (SELW+1)'(N))
      win = SELW'(sum - (SELW+1)'(N));
    else
      win = SELW'(sum);
  end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin owner of a shared mux path with a break-before-make gap.
// Define MUX_SHARE_ARB_TIMEOUT_EN to bound ownership to MAX_HOLD cycles.
module mux_share_arbiter
  import mux_share_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  mux_share_arbiter_if.slave bus
);

  localparam int SELW = $clog2(N);

  if (N < 2 || N > MAXN || MAX_HOLD < 1) begin : g_bad_cfg
    $error("mux_share_arbiter: N must be 2..16, MAX_HOLD >= 1");
  end

  arb_state_t      state;
  logic [N-1:0]    grant;
  logic [N-1:0]    grant_nx;
  logic [SELW-1:0] sel;
  logic [SELW-1:0] ptr;
  logic [SELW-1:0] ptr_nx;
  logic [SELW-1:0] win;
  logic            valid;
  logic            owner_rel;
  logic            hold_hit;
  logic            rel;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr),
    .win   (win),
    .valid (valid)
  );

  assign grant_nx  = N'(onehot(IDXW'(win)));
  // only the owner's done/req matter; sel is the owner index in OWN
  assign owner_rel = bus.done[sel] | ~bus.req[sel];
  assign rel       = owner_rel | hold_hit;
  assign ptr_nx    = (sel == SELW'(N - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      sel   <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        OWN: begin
          if (rel) begin
            state <= GAP;
            grant <= '0;
            ptr   <= ptr_nx;
          end
        end
        default: begin
          if (valid) begin
            state <= OWN;
            grant <= grant_nx;
            sel   <= win;
          end else begin
            state <= IDLE;
            grant <= '0;
          end
        end
      endcase
    end
  end

  assign bus.grant = grant;
  assign bus.sel   = sel;
  assign bus.busy  = (state == OWN);

`ifdef MUX_SHARE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt;
  logic          timeout;

  assign hold_hit = (state == OWN) &&
                    (hold_cnt == CW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= hold_hit & ~owner_rel;
      if (state != OWN) hold_cnt <= '0;
      else              hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign bus.timeout = timeout;
`else
  assign hold_hit    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Directed bench for mux_share_arbiter (N=4, MAX_HOLD=16).
// Covers both builds of MUX_SHARE_ARB_TIMEOUT_EN.
module tb_mux_share_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mux_share_arbiter_if #(.N(4)) bus ();

  mux_share_arbiter #(
    .N        (4),
    .MAX_HOLD (16)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
    tbl[1]  = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[4]  = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1};
    tbl[5]  = '{4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1};
    tbl[6]  = '{4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0};
    tbl[7]  = '{4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1};
    tbl[8]  = '{4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1};
    tbl[9]  = '{4'b1010, 4'b0010, 4'b0000, 2'd1, 1'b0};
    tbl[10] = '{4'b1010, 4'b0000, 4'b1000, 2'd3, 1'b1};
    tbl[11] = '{4'b1010, 4'b1000, 4'b0000, 2'd3, 1'b0};
    tbl[12] = '{4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0};
    tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0};

    // reset holds everything low even with all requests up
    reset_n  = 1'b0;
    bus.req  = 4'b1111;
    bus.done = '0;
    tick();
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_sel", 32'(bus.sel), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);
    reset_n = 1'b1;
    tick();
    tick();
    check("rel_grant", 32'(bus.grant), 32'h1);
    check("rel_busy", 32'(bus.busy), 32'h1);

    // table: one record per clock, from a fresh reset
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.req  = tbl[i].req;
      bus.done = tbl[i].done;
      tick();
      check($sformatf("tbl%0d_grant", i), 32'(bus.grant), 32'(tbl[i].grant));
      check($sformatf("tbl%0d_sel", i), 32'(bus.sel), 32'(tbl[i].sel));
      check($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_to", i), 32'(bus.timeout), 32'h0);
    end

    // full rotation with wrap, one empty cycle between owners
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] exp;
      exp = 4'(1 << (i % 4));
      tick();
      check($sformatf("rr%0d_own1", i), 32'(bus.grant), 32'(exp));
      check($sformatf("rr%0d_sel", i), 32'(bus.sel), 32'(i % 4));
      tick();
      check($sformatf("rr%0d_own2", i), 32'(bus.grant), 32'(exp));
      bus.done = exp;
      tick();
      bus.done = '0;
      check($sformatf("rr%0d_gap", i), 32'(bus.grant), 32'h0);
      check($sformatf("rr%0d_gapbusy", i), 32'(bus.busy), 32'h0);
    end

    // non-owner done and req toggling are ignored
    do_reset();
    bus.req = 4'b0010;
    tick();
    check("ign_own", 32'(bus.grant), 32'h2);
    for (int i = 0; i < 4; i++) begin
      bus.done = 4'b1000;
      bus.req  = (i % 2 == 0) ? 4'b1010 : 4'b0010;
      tick();
      check($sformatf("ign%0d_grant", i), 32'(bus.grant), 32'h2);
    end
    bus.done = 4'b0010;
    bus.req  = 4'b1010;
    tick();
    bus.done = '0;
    check("ign_rel", 32'(bus.grant), 32'h0);
    tick();
    check("ign_next", 32'(bus.grant), 32'h8);

    // async reset mid-ownership clears grant and pointer
    do_reset();
    bus.req = 4'b0010;
    tick();
    bus.req = 4'b0000;
    tick();
    bus.req = 4'b0100;
    tick();
    check("amid_own", 32'(bus.grant), 32'h4);
    reset_n = 1'b0;
    #1;
    check("amid_grant", 32'(bus.grant), 32'h0);
    check("amid_busy", 32'(bus.busy), 32'h0);
    check("amid_sel", 32'(bus.sel), 32'h0);
    #1;
    reset_n = 1'b1;
    bus.req = 4'b0101;
    tick();
    check("amid_ptr0", 32'(bus.grant), 32'h1);

    do_reset();
    bus.req = 4'b0001;
`ifdef MUX_SHARE_ARB_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      check($sformatf("hold%0d_grant", i), 32'(bus.grant), 32'h1);
      check($sformatf("hold%0d_to", i), 32'(bus.timeout), 32'h0);
    end
    tick();
    check("to_pulse", 32'(bus.timeout), 32'h1);
    check("to_gap", 32'(bus.grant), 32'h0);
    bus.req = 4'b0011;
    tick();
    check("to_clear", 32'(bus.timeout), 32'h0);
    check("to_next", 32'(bus.grant), 32'h2);
`else
    for (int i = 1; i <= 100; i++) begin
      tick();
      check($sformatf("hold%0d_grant", i), 32'(bus.grant), 32'h1);
      check($sformatf("hold%0d_to", i), 32'(bus.timeout), 32'h0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
